// File: rtl/cm0ik_gpio_seq_pkg.sv
// Shared types and constants for the GPIO pattern sequencer.
package cm0ik_gpio_seq_pkg;

  // Sequencer states: one address and one data phase per bus write, plus the entry delay.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIR_A,
    ST_DIR_D,
    ST_DAT_A,
    ST_DAT_D,
    ST_WAIT
  } state_e;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0]  HSIZE_WORD    = 3'b010;

  // Register offsets inside the GPIO slave.
  localparam logic [31:0] GPIO_DATA_OFS = 32'h0000_0000;
  localparam logic [31:0] GPIO_DIR_OFS  = 32'h0000_0400;

endpackage

// File: rtl/cm0ik_gpio_seq_tbl.sv
// Pattern table: DEPTH entries of (data, delay), one synchronous write port,
// one asynchronous read port addressed by the entry being played.
module cm0ik_gpio_seq_tbl #(
  parameter  int DEPTH = 8,
  parameter  int DLY_W = 16,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IW-1:0]    waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [DLY_W-1:0] wdly_i,
  input  logic [IW-1:0]    raddr_i,
  output logic [31:0]      rdata_o,
  output logic [DLY_W-1:0] rdly_o
);

  logic [31:0]      data_q [DEPTH];
  logic [DLY_W-1:0] dly_q  [DEPTH];

  // Table write port.
  // NOTE: storage arrays carry no reset; software writes every entry it plays,
  // and leaving them unreset lets synthesis map them to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      data_q[waddr_i] <= wdata_i;
      dly_q[waddr_i]  <= wdly_i;
    end
  end

  assign rdata_o = data_q[raddr_i];
  assign rdly_o  = dly_q[raddr_i];

endmodule

// File: rtl/cm0ik_gpio_seq.sv
// AHB-Lite master that writes the GPIO direction register once, then plays a
// table of (data, delay) entries into the GPIO data-out register.
module cm0ik_gpio_seq
  import cm0ik_gpio_seq_pkg::*;
#(
  parameter  logic [31:0] GPIO_BASE = 32'h4000_0000,
  parameter  int          DEPTH     = 8,
  parameter  int          DLY_W     = 16,
  localparam int          IW        = $clog2(DEPTH)
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic             HRESP,
  input  logic             tbl_we,
  input  logic [IW-1:0]    tbl_addr,
  input  logic [31:0]      tbl_data,
  input  logic [DLY_W-1:0] tbl_dly,
  input  logic [31:0]      dir_value,
  input  logic [IW:0]      seq_len,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [IW-1:0]    cur_idx
);

  localparam logic [IW:0] LEN_MAX = (IW + 1)'(DEPTH);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW:0]      len_q, len_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hwdata_q, hwdata_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             stop_pend_q, stop_pend_d;

  logic [31:0]      rd_data;
  logic [DLY_W-1:0] rd_dly;
  logic             start_ok;
  logic             last_entry;
  logic             entry_end;

  cm0ik_gpio_seq_tbl #(
    .DEPTH (DEPTH),
    .DLY_W (DLY_W)
  ) u_tbl (
    .clk     (HCLK),
    .we_i    (tbl_we),
    .waddr_i (tbl_addr),
    .wdata_i (tbl_data),
    .wdly_i  (tbl_dly),
    .raddr_i (idx_q),
    .rdata_o (rd_data),
    .rdly_o  (rd_dly)
  );

  // Stop beats start when both arrive together; out-of-range lengths are ignored.
  assign start_ok   = start && !stop && (seq_len != '0) && (seq_len <= LEN_MAX);
  // The run length is latched at start so a mid-run change cannot strand the index.
  assign last_entry = (({1'b0, idx_q} + 1'b1) == len_q);

  // Next-state logic: sequencing, stop/error handling and index advance.
  // NOTE: every _d gets its hold value first so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    hwdata_d    = hwdata_q;
    err_d       = err_q;
    done_d      = 1'b0;
    stop_pend_d = stop_pend_q;
    entry_end   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d     = ST_DIR_A;
          idx_d       = '0;
          len_d       = seq_len;
          err_d       = 1'b0;
          stop_pend_d = 1'b0;
        end
      end

      ST_DIR_A, ST_DAT_A: begin
        // A started transfer is never abandoned; remember the stop for later.
        if (stop) stop_pend_d = 1'b1;
        if (HREADY) begin
          hwdata_d = (state_q == ST_DIR_A) ? dir_value : rd_data;
          state_d  = (state_q == ST_DIR_A) ? ST_DIR_D : ST_DAT_D;
        end
      end

      ST_DIR_D, ST_DAT_D: begin
        if (stop)  stop_pend_d = 1'b1;
        if (HRESP) err_d       = 1'b1;
        if (HREADY) begin
          if (HRESP || err_q || stop || stop_pend_q) begin
            state_d = ST_IDLE;
          end else if (state_q == ST_DIR_D) begin
            state_d = ST_DAT_A;
          end else if (rd_dly == '0) begin
            entry_end = 1'b1;
          end else begin
            cnt_d   = rd_dly;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DLY_W'(1)) begin
          entry_end = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (entry_end) begin
      if (!last_entry) begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_DAT_A;
      end else if (loop_en) begin
        idx_d   = '0;
        state_d = ST_DAT_A;
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // State and datapath registers.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      hwdata_q    <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      hwdata_q    <= hwdata_d;
      err_q       <= err_d;
      done_q      <= done_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  logic addr_phase;
  assign addr_phase = (state_q == ST_DIR_A) || (state_q == ST_DAT_A);

  assign HTRANS  = addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HWRITE  = addr_phase;
  assign HADDR   = GPIO_BASE + ((state_q == ST_DIR_A) ? GPIO_DIR_OFS : GPIO_DATA_OFS);
  assign HSIZE   = HSIZE_WORD;
  assign HWDATA  = hwdata_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign cur_idx = idx_q;

endmodule

// File: tb/tb_cm0ik_gpio_seq.sv
// Self-checking bench for cm0ik_gpio_seq: behavioural bus-phase model, per-cycle
// compare process, bus transaction log and hand-computed directed checks.
module tb_cm0ik_gpio_seq;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam int          DEPTH = 8;
  localparam int          DLY_W = 16;
  localparam int          IW    = 3;

  // Bus phases of the behavioural model (what the bus is doing, not RTL states).
  localparam int P_IDLE = 0, P_ADDR = 1, P_DATA = 2, P_WAIT = 3;

  logic             HCLK, HRESETn;
  logic [31:0]      HADDR, HWDATA, tbl_data, dir_value;
  logic [1:0]       HTRANS;
  logic             HWRITE, HREADY, HRESP;
  logic [2:0]       HSIZE;
  logic             tbl_we, loop_en, start, stop, busy, done, err;
  logic [IW-1:0]    tbl_addr, cur_idx;
  logic [DLY_W-1:0] tbl_dly;
  logic [IW:0]      seq_len;

  cm0ik_gpio_seq dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .tbl_we    (tbl_we),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .tbl_dly   (tbl_dly),
    .dir_value (dir_value),
    .seq_len   (seq_len),
    .loop_en   (loop_en),
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cur_idx   (cur_idx)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_bus, m_idx, m_len, m_left, m_wr_cnt;
  bit          m_dir, m_stopreq, m_err, m_errph, m_done;
  logic [31:0] m_hw;
  logic [31:0] m_tdata [DEPTH];
  int          m_tdly  [DEPTH];

  function automatic void model_reset();
    m_bus = P_IDLE; m_dir = 0; m_idx = 0; m_len = 0; m_left = 0; m_wr_cnt = 0;
    m_stopreq = 0; m_err = 0; m_errph = 0; m_done = 0; m_hw = '0;
  endfunction

  // One clock of the spec rules: write, then wait the entry's delay, then next entry.
  function automatic void model_step();
    bit ent_end = 0;
    m_done = 0;
    case (m_bus)
      P_IDLE: if (start && !stop && seq_len >= 1 && int'(seq_len) <= DEPTH) begin
        m_bus = P_ADDR; m_dir = 1; m_idx = 0; m_len = int'(seq_len);
        m_err = 0; m_errph = 0; m_stopreq = 0; m_wr_cnt = 0;
      end
      P_ADDR: begin
        if (stop) m_stopreq = 1;
        if (HREADY) begin
          m_hw = m_dir ? dir_value : m_tdata[m_idx];
          if (!m_dir) m_wr_cnt++;
          m_bus = P_DATA;
        end
      end
      P_DATA: begin
        if (stop)  m_stopreq = 1;
        if (HRESP) begin m_err = 1; m_errph = 1; end
        if (HREADY) begin
          if (m_errph || m_stopreq)    m_bus = P_IDLE;
          else if (m_dir)              begin m_dir = 0; m_bus = P_ADDR; end
          else if (m_tdly[m_idx] == 0) ent_end = 1;
          else                         begin m_left = m_tdly[m_idx]; m_bus = P_WAIT; end
        end
      end
      default: begin
        if (stop)             m_bus = P_IDLE;
        else if (m_left == 1) ent_end = 1;
        else                  m_left--;
      end
    endcase
    if (ent_end) begin
      if (m_idx != m_len - 1) begin m_idx++; m_bus = P_ADDR; end
      else if (loop_en)       begin m_idx = 0; m_bus = P_ADDR; end
      else                    begin m_bus = P_IDLE; m_done = 1; end
    end
    if (tbl_we) begin
      m_tdata[tbl_addr] = tbl_data;
      m_tdly[tbl_addr]  = int'(tbl_dly);
    end
  endfunction

  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) model_reset();
    else          model_step();

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;

  task automatic compare_cycle();
    check("htrans", 32'(HTRANS), (m_bus == P_ADDR) ? 32'd2 : 32'd0);
    check("hwrite", 32'(HWRITE), 32'(m_bus == P_ADDR));
    check("hsize",  32'(HSIZE),  32'd2);
    if (m_bus == P_ADDR) check("haddr", HADDR, BASE + (m_dir ? 32'h400 : 32'h0));
    if (m_bus == P_DATA) check("hwdata", HWDATA, m_hw);
    check("busy",    32'(busy),    32'(m_bus != P_IDLE));
    check("done",    32'(done),    32'(m_done));
    check("err",     32'(err),     32'(m_err));
    check("cur_idx", 32'(cur_idx), 32'(m_idx));
  endtask

  always @(negedge HCLK)
    if (HRESETn && cmp_en) compare_cycle();

  // ---------------- bus transaction log ----------------
  logic [31:0] log_addr[$], log_data[$];
  int          log_cyc[$];
  int          cyc, done_cnt;
  bit          dp_pend;

  function automatic void mon_step();
    cyc++;
    if (dp_pend && HREADY) begin log_data.push_back(HWDATA); dp_pend = 0; end
    if (HTRANS == 2'b10 && HREADY) begin
      log_addr.push_back(HADDR); log_cyc.push_back(cyc); dp_pend = 1;
    end
    if (done) done_cnt++;
  endfunction

  function automatic void mon_reset();
    dp_pend = 0;
  endfunction

  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) mon_reset();
    else          mon_step();

  function automatic void log_clear();
    log_addr.delete(); log_data.delete(); log_cyc.delete();
  endfunction

  function automatic int count_dir();
    int n = 0;
    foreach (log_addr[i]) if (log_addr[i] == BASE + 32'h400) n++;
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  bit rdy_rand  = 0;
  int resp_mode = 0;   // 0 none, 1 random in data phases, 2 on the second data write

  task automatic step();
    @(negedge HCLK);
    start = 0; stop = 0; tbl_we = 0;
    HREADY = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    HRESP  = 1'b0;
    if (m_bus == P_DATA && !m_dir) begin
      if (resp_mode == 1 && $urandom_range(0, 15) == 0) HRESP = 1'b1;
      if (resp_mode == 2 && m_wr_cnt == 2)              HRESP = 1'b1;
    end
  endtask

  task automatic wr_tbl(input int a, input logic [31:0] d, input int dl);
    step();
    tbl_we = 1; tbl_addr = IW'(a); tbl_data = d; tbl_dly = DLY_W'(dl);
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    do begin step(); n++; end while (busy && n < max);
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_phase(input int ph, input bit dir, input int max, input string name);
    int n = 0;
    bit hit = 0;
    while (!hit && n < max) begin
      step(); n++;
      hit = (m_bus == ph) && (m_dir == dir);
    end
    check(name, 32'(hit), 32'd1);
  endtask

  task automatic reset_checks(input string p);
    check({p, "_htrans"}, 32'(HTRANS), 32'd0);
    check({p, "_haddr"},  HADDR,       BASE);
    check({p, "_hwrite"}, 32'(HWRITE), 32'd0);
    check({p, "_hsize"},  32'(HSIZE),  32'd2);
    check({p, "_hwdata"}, HWDATA,      32'd0);
    check({p, "_busy"},   32'(busy),   32'd0);
    check({p, "_done"},   32'(done),   32'd0);
    check({p, "_err"},    32'(err),    32'd0);
    check({p, "_idx"},    32'(cur_idx), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, d0;
    HRESETn = 1; HREADY = 1; HRESP = 0; tbl_we = 0; tbl_addr = '0; tbl_data = '0;
    tbl_dly = '0; dir_value = '0; seq_len = '0; loop_en = 0; start = 0; stop = 0;
    #1 HRESETn = 0;
    #12 reset_checks("rst");
    step(); HRESETn = 1;
    step(); cmp_en = 1;

    for (int i = 0; i < DEPTH; i++) wr_tbl(i, $urandom, i % 3);

    // Basic play: three entries, delays 0,2,0.
    wr_tbl(0, 32'h11, 0); wr_tbl(1, 32'h22, 2); wr_tbl(2, 32'h33, 0);
    step(); log_clear(); d0 = done_cnt;
    dir_value = 32'hA5A5_0F0F; seq_len = 4'd3; loop_en = 0; start = 1;
    wait_idle(100, "basic_idle");
    step(); step();
    check("basic_nwr", 32'(log_addr.size()), 32'd4);
    if (log_addr.size() == 4 && log_data.size() == 4) begin
      check("basic_a0", log_addr[0], BASE + 32'h400);
      check("basic_a1", log_addr[1], BASE);
      check("basic_d0", log_data[0], 32'hA5A5_0F0F);
      check("basic_d1", log_data[1], 32'h11);
      check("basic_d2", log_data[2], 32'h22);
      check("basic_d3", log_data[3], 32'h33);
      check("basic_gap1", 32'(log_cyc[1] - log_cyc[0]), 32'd2);
      check("basic_gap2", 32'(log_cyc[2] - log_cyc[1]), 32'd2);
      check("basic_gap3", 32'(log_cyc[3] - log_cyc[2]), 32'd4);
    end
    check("basic_done", 32'(done_cnt - d0), 32'd1);

    // Same pattern under random wait states: data unchanged.
    rdy_rand = 1;
    step(); log_clear(); start = 1;
    wait_idle(300, "ws_idle");
    step(); step();
    rdy_rand = 0;
    check("ws_nwr", 32'(log_data.size()), 32'd4);
    if (log_data.size() == 4) check("ws_d3", log_data[3], 32'h33);

    // Loop: two entries, single direction write, pattern 0,1,0,1.
    wr_tbl(0, 32'hA0, 1); wr_tbl(1, 32'hB1, 0);
    step(); log_clear(); d0 = done_cnt; seq_len = 4'd2; loop_en = 1; start = 1;
    n = 0;
    while (log_data.size() < 5 && n < 100) begin step(); n++; end
    check("loop_n", 32'(log_data.size() >= 5), 32'd1);
    check("loop_dir", 32'(count_dir()), 32'd1);
    if (log_data.size() >= 5) begin
      check("loop_d1", log_data[1], 32'hA0);
      check("loop_d2", log_data[2], 32'hB1);
      check("loop_d3", log_data[3], 32'hA0);
      check("loop_d4", log_data[4], 32'hB1);
    end
    wait_phase(P_WAIT, 0, 20, "stopw_reach");
    stop = 1;
    step(); step();
    check("stopw_busy", 32'(busy), 32'd0);
    check("stopw_done", 32'(done_cnt - d0), 32'd0);

    // Stop during a data address phase: that write still completes.
    step(); log_clear(); start = 1;
    wait_phase(P_ADDR, 0, 20, "stopa_reach");
    stop = 1;
    wait_idle(20, "stopa_idle");
    step();
    check("stopa_cmpl", 32'(log_data.size()), 32'(log_addr.size()));
    check("stopa_done", 32'(done_cnt - d0), 32'd0);

    // Error on the second data write.
    wr_tbl(0, 32'h1, 0); wr_tbl(1, 32'h2, 0); wr_tbl(2, 32'h3, 0);
    resp_mode = 2;
    step(); log_clear(); d0 = done_cnt; seq_len = 4'd3; loop_en = 0; start = 1;
    wait_idle(50, "err_idle");
    step(); step();
    resp_mode = 0;
    check("err_set", 32'(err), 32'd1);
    check("err_nwr", 32'(log_addr.size()), 32'd3);
    check("err_done", 32'(done_cnt - d0), 32'd0);
    step(); start = 1;
    step();
    check("err_clr", 32'(err), 32'd0);
    wait_idle(50, "err2_idle");

    // Ignored starts.
    step(); log_clear(); seq_len = 4'd0; start = 1;
    repeat (4) step();
    seq_len = 4'd9; start = 1;
    repeat (4) step();
    seq_len = 4'd2; start = 1; stop = 1;
    repeat (4) step();
    check("ign_nwr", 32'(log_addr.size()), 32'd0);
    seq_len = 4'd3; start = 1;
    repeat (3) step();
    start = 1;
    wait_idle(50, "busy_idle");
    check("busy_ndir", 32'(count_dir()), 32'd1);

    // Randomized runs.
    for (int r = 0; r < 40; r++) begin
      rdy_rand  = 1'($urandom_range(0, 1));
      resp_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      step();
      seq_len = 4'($urandom_range(0, 10)); loop_en = 1'($urandom_range(0, 1));
      dir_value = $urandom; start = 1;
      for (int c = 0; c < 80; c++) begin
        step();
        case ($urandom_range(0, 29))
          0:       stop = 1;
          1:       start = 1;
          2:       loop_en = ~loop_en;
          3, 4:    begin
                     tbl_we = 1; tbl_addr = IW'($urandom_range(0, DEPTH - 1));
                     tbl_data = $urandom; tbl_dly = DLY_W'($urandom_range(0, 3));
                   end
          default: ;
        endcase
      end
      step(); stop = 1;
      wait_idle(100, "rand_idle");
    end
    rdy_rand = 0; resp_mode = 0;

    // Reset in the middle of a data phase.
    step(); seq_len = 4'd4; loop_en = 1; start = 1;
    wait_phase(P_DATA, 0, 30, "rstm_reach");
    #2 HRESETn = 0;
    #1 reset_checks("rstm");
    step(); HRESETn = 1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
